// File: rtl/edge_pulse_gen.sv
// edge_pulse_gen: turns a one-cycle start command into a timed pulse train.
// Ports:
//   clk, rst_n (sync, active-low), start, abort        - control inputs
//   cfg_delay/cfg_high/cfg_low (CNT_W), cfg_num (NUM_W) - train shape,
//                                                        latched at start
//   pulse_out, busy, done                              - registered outputs
module edge_pulse_gen #(
    parameter int CNT_W = 16,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_low,
    input  logic [NUM_W-1:0] cfg_num,
    output logic             pulse_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [NUM_W-1:0] NUM_ONE = 1;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] low_q;
    logic [NUM_W-1:0] num_q;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;

    logic             cfg_ok;
    logic             cnt_last;
    logic [CNT_W-1:0] low_eff;

    // A zero pulse count or zero width yields an empty train.
    assign cfg_ok   = (cfg_num != '0) && (cfg_high != '0);
    assign cnt_last = (cnt_q == CNT_ONE);
    // A zero gap would merge pulses, so it is stretched to one cycle.
    assign low_eff  = (cfg_low == '0) ? CNT_ONE : cfg_low;

    // Outputs are registered alongside the state so every output is a
    // pure flop with no input-to-output combinational path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            high_q  <= '0;
            low_q   <= '0;
            num_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort && (state_q != S_IDLE)) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (start && !abort) begin
                        high_q <= cfg_high;
                        low_q  <= low_eff;
                        num_q  <= cfg_num;
                        if (!cfg_ok) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (cfg_delay != '0) begin
                            state_q <= S_DELAY;
                            cnt_q   <= cfg_delay;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_HIGH;
                            cnt_q   <= cfg_high;
                            busy_q  <= 1'b1;
                            pulse_q <= 1'b1;
                        end
                    end
                end
                S_DELAY: begin
                    if (cnt_last) begin
                        state_q <= S_HIGH;
                        cnt_q   <= high_q;
                        pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (cnt_last) begin
                        num_q   <= num_q - NUM_ONE;
                        pulse_q <= 1'b0;
                        if (num_q == NUM_ONE) begin
                            state_q <= S_DONE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_LOW;
                            cnt_q   <= low_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_LOW: begin
                    if (cnt_last) begin
                        state_q <= S_HIGH;
                        cnt_q   <= high_q;
                        pulse_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    pulse_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
